// File: rtl/dft_host_seq.sv
// Host-side DFT dump initiator: REQ/ACK handshake, strobe capture FIFO, commit ack.
// Ports: clk, reset(async, active-low), start, busy, done; dft_val_op, dft_op_ack,
// dft_out, dft_out_strobe, dft_op_commit, dft_commit_ack; rd_data/rd_valid/rd_ready
// FIFO read side; word_cnt, err_ovf, err_cnt, err_timeout status.
// Optional macro DFT_HOST_TIMEOUT_EN enables the handshake timeout.
module dft_host_seq #(
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned EXP_WORDS   = 32,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        dft_val_op,
  input  logic        dft_op_ack,
  input  logic [31:0] dft_out,
  input  logic        dft_out_strobe,
  input  logic        dft_op_commit,
  output logic        dft_commit_ack,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [15:0] word_cnt,
  output logic        err_ovf,
  output logic        err_cnt,
  output logic        err_timeout
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE, REQ, STREAM, CACK
  } state_t;

  state_t state_q, state_d;

  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          rd_valid_q, rd_valid_d;
  logic [31:0]   rd_data_q, rd_data_d;
  logic [15:0]   word_cnt_q, word_cnt_d;
  logic          err_ovf_q, err_ovf_d;
  logic          err_cnt_q, err_cnt_d;
  logic          err_tmo_q, err_tmo_d;

  logic clr, tmo_hit, tmo_fire;
  logic cap, full, pop, push;

`ifdef DFT_HOST_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC);

  logic [TW-1:0] tmo_q, tmo_d;

  assign tmo_hit = (state_q == REQ || state_q == STREAM) &&
                   (tmo_q == TW'(TIMEOUT_CYC - 1));

  // Restarts on every state change so REQ and STREAM each get a full budget.
  always_comb begin
    tmo_d = tmo_q;
    if (state_d != state_q)
      tmo_d = '0;
    else if (state_q == REQ || state_q == STREAM)
      tmo_d = tmo_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    clr      = 1'b0;
    tmo_fire = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = REQ;
          clr     = 1'b1;
        end
      end
      REQ: begin
        if (dft_op_ack) begin
          state_d = STREAM;
        end else if (tmo_hit) begin
          state_d  = IDLE;
          tmo_fire = 1'b1;
        end
      end
      STREAM: begin
        if (dft_op_commit) begin
          state_d = CACK;
        end else if (tmo_hit) begin
          state_d  = IDLE;
          tmo_fire = 1'b1;
        end
      end
      CACK:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cap  = (state_q != IDLE) && dft_out_strobe;
    full = (cnt_q == (AW+1)'(FIFO_DEPTH));
    pop  = rd_valid_q && rd_ready;
    push = cap && (!full || pop);

    wr_ptr_d   = wr_ptr_q + AW'(push);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    cnt_d      = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    rd_valid_d = (cnt_d != '0);

    // Next head is either the word being written this cycle or one in memory.
    rd_data_d = rd_data_q;
    if (push && rd_ptr_d == wr_ptr_q)
      rd_data_d = dft_out;
    else if (cnt_d != '0)
      rd_data_d = mem[rd_ptr_d];

    word_cnt_d = clr ? 16'h0 : word_cnt_q;
    if (cap && word_cnt_q != 16'hFFFF)
      word_cnt_d = word_cnt_q + 16'h1;

    err_ovf_d = clr ? 1'b0 : (err_ovf_q | (cap && !push));

    // word_cnt_q here already holds any strobe taken on the commit cycle.
    err_cnt_d = clr ? 1'b0 : err_cnt_q;
    if (state_q == CACK)
      err_cnt_d = (word_cnt_q != 16'(EXP_WORDS));

    err_tmo_d = clr ? 1'b0 : (err_tmo_q | tmo_fire);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= dft_out;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      word_cnt_q <= '0;
      err_ovf_q  <= 1'b0;
      err_cnt_q  <= 1'b0;
      err_tmo_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      word_cnt_q <= word_cnt_d;
      err_ovf_q  <= err_ovf_d;
      err_cnt_q  <= err_cnt_d;
      err_tmo_q  <= err_tmo_d;
    end
  end

  assign busy           = (state_q != IDLE);
  assign dft_val_op     = (state_q == REQ);
  assign dft_commit_ack = (state_q == CACK);
  assign done           = (state_q == CACK);
  assign rd_data        = rd_data_q;
  assign rd_valid       = rd_valid_q;
  assign word_cnt       = word_cnt_q;
  assign err_ovf        = err_ovf_q;
  assign err_cnt        = err_cnt_q;
  assign err_timeout    = err_tmo_q;

endmodule

// File: doc/dft_host_seq.md
Name: dft_host_seq

Overview:
- Host-side initiator for the DFT dump handshake.
- Drives dft_val_op, consumes dft_op_ack, captures each dft_out word qualified by dft_out_strobe into an internal FIFO, and closes the transaction by acknowledging dft_op_commit.
- Sits between the system/test controller and the DFT top; the counterpart of the DFT control responder.

Parameters:
- FIFO_DEPTH, 16, capture FIFO depth in 32-bit words; power of 2, at least 2.
- EXP_WORDS, 32, words expected per dump (chain_len × dump_nbr); used for the mismatch check.
- TIMEOUT_CYC, 1024, handshake timeout in cycles (used only with the optional feature).

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to run one dump; honoured only in IDLE.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse on the cycle commit_ack is driven.
- dft_val_op  out  1  operation request to the responder.
- dft_op_ack  in  1  responder accepted the request.
- dft_out  in  32  scan data word.
- dft_out_strobe  in  1  dft_out valid this cycle.
- dft_op_commit  in  1  responder finished the dump.
- dft_commit_ack  out  1  acknowledge of commit.
- rd_data  out  32  FIFO head word.
- rd_valid  out  1  FIFO non-empty.
- rd_ready  in  1  consumer pops the head when rd_valid && rd_ready.
- word_cnt  out  16  strobes captured in the current/last dump; saturates at 16'hFFFF.
- err_ovf  out  1  sticky: a strobe arrived while the FIFO was full.
- err_cnt  out  1  sticky: word_cnt != EXP_WORDS at commit.
- err_timeout  out  1  sticky: handshake timeout (optional feature).

Behaviour:
- Reset values: all outputs 0; FIFO empty; rd_data 0; FSM in IDLE. Reset mid-transaction aborts immediately: dft_val_op and dft_commit_ack drop asynchronously and FIFO contents are discarded.
- FSM states: IDLE, REQ, STREAM, CACK.
  - IDLE: on start → REQ. In the same transition, clear word_cnt, err_cnt, err_ovf and err_timeout. FIFO contents are kept.
  - REQ: dft_val_op=1 (registered output, high the cycle after start). On the cycle dft_op_ack=1 is sampled → STREAM; dft_val_op is 0 from the next cycle.
  - STREAM: wait for dft_op_commit=1 → CACK.
  - CACK: dft_commit_ack=1 and done=1 for exactly one cycle. Update err_cnt, using word_cnt including any strobe captured on the commit cycle. Next state is IDLE.
- Strobe capture: active in REQ, STREAM and CACK. In IDLE, strobes are ignored and not counted.
  - Each captured strobe increments word_cnt (saturating).
  - It pushes dft_out into the FIFO if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
  - Otherwise the word is dropped and err_ovf is set; word_cnt still increments.
- Start while busy: ignored, no error.
- FIFO:
  - Circular buffer with a log2(FIFO_DEPTH)+1-bit count; pointers wrap modulo FIFO_DEPTH.
  - rd_data and rd_valid are registered, with no bypass: a word pushed into an empty FIFO appears on rd_valid the next cycle.
  - Simultaneous push and pop when empty: pop is a no-op, push succeeds.
  - rd_ready with rd_valid=0: no effect.
- dft_val_op and dft_commit_ack are never high together. dft_commit_ack is never high for two consecutive cycles.

Optional Feature:
- Macro: DFT_HOST_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to REQ and STREAM and counts while in either state.
  - On reaching TIMEOUT_CYC-1 without the exit condition, set err_timeout and go to IDLE. dft_val_op drops and no commit_ack is sent.
  - The counter width is clog2(TIMEOUT_CYC).
- Undefined: no counter is instantiated, the FSM waits indefinitely, and err_timeout is tied to 0.

Test Plan:
- Nominal dump: start; ack after 3 cycles; 32 strobes of 0x1000+i; commit → dft_val_op high 3 cycles. One commit_ack/done pulse. word_cnt=32, err_cnt=0. FIFO (depth 16, rd_ready=1 throughout) delivers 0x1000..0x101F in order.
- Overflow: rd_ready=0, 20 strobes with FIFO_DEPTH=16 → first 16 words stored, err_ovf=1, word_cnt=20, err_cnt=1. Draining yields words 0..15.
- Full with simultaneous pop: FIFO full, rd_ready=1 and strobe in the same cycle → push accepted, err_ovf stays 0, count stays 16.
- Start ignored and reset abort: start pulse in STREAM → no effect. Assert reset mid-STREAM with 5 words buffered → all outputs 0 asynchronously, FIFO empty after release, FSM in IDLE.
- Timeout (DFT_HOST_TIMEOUT_EN, TIMEOUT_CYC=8): dft_op_ack never asserted → dft_val_op drops after 8 cycles in REQ, err_timeout=1, busy=0. With the macro undefined, dft_val_op remains high after 100 cycles.
- Commit-cycle strobe: strobe coincident with dft_op_commit → word captured, counted in word_cnt before the err_cnt evaluation (EXP_WORDS met exactly → err_cnt=0).
